// File: rtl/clk_rst_seq_if.sv
// Sequencer <-> clock-wizard / downstream-reset signal bundle.
// Every signal here is a level, not a handshake. There is no valid/ready pair.
// The master (clk_rst_seq) drives the reset, status and debug levels, and updates them only on clk_in1 edges.
// The slave drives mmcm_locked, which may change at any time.
interface clk_rst_seq_if;
  logic       mmcm_locked;
  logic       mmcm_reset;
  logic       sys_rst;
  logic       lock_fail;
  logic [2:0] retry_cnt;
  logic [2:0] seq_state;

  modport master (
    input  mmcm_locked,
    output mmcm_reset,
    output sys_rst,
    output lock_fail,
    output retry_cnt,
    output seq_state
  );

  modport slave (
    output mmcm_locked,
    input  mmcm_reset,
    input  sys_rst,
    input  lock_fail,
    input  retry_cnt,
    input  seq_state
  );
endinterface

// File: rtl/clk_rst_seq.sv
// Reset/lock sequencer for the clock wizard feeding clk_sys.
// - Pulses the wizard reset and waits for a stable lock before it releases sys_rst.
// - Re-pulses the wizard when lock times out.
// - Optional feature macro: CLK_RST_SEQ_RETRY_EN.
//   - When defined, a timeout re-pulses the wizard up to MAX_RETRY times before FAIL.
//   - When undefined, any timeout goes straight to FAIL and retry_cnt stays 0.
module clk_rst_seq #(
  parameter int RST_HOLD_CYC = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int STABLE_CYC   = 256,
  parameter int MAX_RETRY    = 4
) (
  input  logic           clk_in1,
  input  logic           reset,
  clk_rst_seq_if.master  seq
);

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

`ifdef CLK_RST_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  // With retries disabled, the retry ceiling is zero. Every timeout then lands in FAIL,
  // and the retry counter never leaves 0.
  localparam logic [2:0] RETRY_MAX = RETRY_EN ? 3'(MAX_RETRY) : 3'd0;

  localparam int MAX_HT  = (RST_HOLD_CYC > LOCK_TIMEOUT) ? RST_HOLD_CYC : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_HT > STABLE_CYC) ? MAX_HT : STABLE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  // A phase ends on the edge where the counter already shows (length - 1).
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             locked_m;
  logic             locked_s;
  logic             mmcm_reset_q;
  logic             sys_rst_q;
  logic             lock_fail_q;
  logic [2:0]       retry_q;

  // Two-flop synchroniser for the asynchronous wizard locked flag.
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= seq.mmcm_locked;
      locked_s <= locked_m;
    end
  end

  // Sequencer FSM. A single shared counter clears on every state change.
  // Outputs are registered alongside each transition.
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      state        <= ST_HOLD;
      cnt          <= '0;
      mmcm_reset_q <= 1'b1;
      sys_rst_q    <= 1'b1;
      lock_fail_q  <= 1'b0;
      retry_q      <= 3'd0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state        <= ST_WAIT_LOCK;
            cnt          <= '0;
            mmcm_reset_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock takes precedence over a timeout that lands on the same edge.
          if (locked_s) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt          <= '0;
            mmcm_reset_q <= 1'b1;
            if (retry_q < RETRY_MAX) begin
              retry_q <= retry_q + 3'd1;
              state   <= ST_HOLD;
            end else begin
              state       <= ST_FAIL;
              lock_fail_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state     <= ST_RUN;
            cnt       <= '0;
            sys_rst_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_RUN: begin
          // Lock loss re-pulses the wizard but does not consume a retry.
          if (!locked_s) begin
            state        <= ST_HOLD;
            cnt          <= '0;
            mmcm_reset_q <= 1'b1;
            sys_rst_q    <= 1'b1;
          end
        end
        ST_FAIL: begin
          mmcm_reset_q <= 1'b1;
          sys_rst_q    <= 1'b1;
          lock_fail_q  <= 1'b1;
        end
        default: begin
          state        <= ST_FAIL;
          cnt          <= '0;
          mmcm_reset_q <= 1'b1;
          sys_rst_q    <= 1'b1;
          lock_fail_q  <= 1'b1;
        end
      endcase
    end
  end

  assign seq.mmcm_reset = mmcm_reset_q;
  assign seq.sys_rst    = sys_rst_q;
  assign seq.lock_fail  = lock_fail_q;
  assign seq.retry_cnt  = retry_q;
  assign seq.seq_state  = state;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq with RST_HOLD_CYC=4, LOCK_TIMEOUT=20, STABLE_CYC=8, MAX_RETRY=2.
// The stimulus schedules each expected output change together with the clock edge it lands on.
// The monitor pops one entry from the queue every time the DUT's output vector changes.
module tb_clk_rst_seq;

  localparam int W = 25;  // {edge[15:0], state[2:0], mmcm_reset, sys_rst, lock_fail, retry_cnt[2:0]}

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [W-1:0] exp_q[$];
  logic [8:0]   exp_cur = 9'h1ff;

  clk_rst_seq_if bus();

  clk_rst_seq #(
    .RST_HOLD_CYC(4),
    .LOCK_TIMEOUT(20),
    .STABLE_CYC  (8),
    .MAX_RETRY   (2)
  ) dut (
    .clk_in1(clk),
    .reset  (reset),
    .seq    (bus.master)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- expected-vector helpers ----------------
  function automatic logic [8:0] v_hold(input logic [2:0] rc);
    return {3'd0, 1'b1, 1'b1, 1'b0, rc};
  endfunction
  function automatic logic [8:0] v_wait(input logic [2:0] rc);
    return {3'd1, 1'b0, 1'b1, 1'b0, rc};
  endfunction
  function automatic logic [8:0] v_stable(input logic [2:0] rc);
    return {3'd2, 1'b0, 1'b1, 1'b0, rc};
  endfunction
  function automatic logic [8:0] v_run(input logic [2:0] rc);
    return {3'd3, 1'b0, 1'b0, 1'b0, rc};
  endfunction
  function automatic logic [8:0] v_fail(input logic [2:0] rc);
    return {3'd4, 1'b1, 1'b1, 1'b1, rc};
  endfunction

  // ---------------- driver tasks ----------------
  // Advance until edge n has happened. Inputs set afterwards are sampled at edge n+1.
  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Schedule an output change at edge c. Vectors equal to the current one are skipped.
  task automatic expect_at(input int c, input logic [8:0] v);
    if (v != exp_cur) begin
      exp_q.push_back({16'(c), v});
      exp_cur = v;
    end
  endtask

  task automatic set_locked(input logic v);
    bus.mmcm_locked = v;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [8:0]   prev;
    logic [8:0]   obs;
    logic [W-1:0] e;
    prev = 9'h1ff;
    forever begin
      @(negedge clk);
      obs = {bus.seq_state, bus.mmcm_reset, bus.sys_rst, bus.lock_fail, bus.retry_cnt};
      if (obs !== prev) begin
        prev = obs;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: edge %0d got vec=%b, required no change", cyc, obs);
        end else begin
          e = exp_q.pop_front();
          if (e[8:0] !== obs || e[24:9] !== 16'(cyc)) begin
            n_fail++;
            $display("FAIL out_event: got vec=%b at edge %0d, required vec=%b at edge %0d",
                     obs, cyc, e[8:0], e[24:9]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    reset = 1'b1;
    set_locked(1'b0);

    // Power-up reset for edges 1..2. Release: edge 3 is HOLD cycle 1.
    expect_at(1, v_hold(3'd0));
    expect_at(6, v_wait(3'd0));
    step_to(2);
    reset = 1'b0;

    // Lock arrives 10 cycles after release. It is sampled at edge 13, so STABLE at 15 and RUN at 13+10.
    step_to(12);
    expect_at(15, v_stable(3'd0));
    expect_at(23, v_run(3'd0));
    set_locked(1'b1);

    // Lock loss in RUN: HOLD within 3 edges, a 4-cycle wizard pulse, then relock.
    step_to(30);
    expect_at(33, v_hold(3'd0));
    expect_at(37, v_wait(3'd0));
    set_locked(1'b0);
    step_to(38);
    expect_at(41, v_stable(3'd0));
    expect_at(49, v_run(3'd0));
    set_locked(1'b1);

    // One-cycle reset while in RUN, with lock still present.
    step_to(52);
    expect_at(53, v_hold(3'd0));
    expect_at(57, v_wait(3'd0));
    expect_at(58, v_stable(3'd0));
    expect_at(66, v_run(3'd0));
    reset = 1'b1;
    step_to(53);
    reset = 1'b0;

    // Glitch in STABLE at count 5: back to WAIT_LOCK, then 8 fresh locked cycles.
    step_to(70);
    expect_at(73, v_hold(3'd0));
    expect_at(77, v_wait(3'd0));
    set_locked(1'b0);
    step_to(78);
    expect_at(81, v_stable(3'd0));
    expect_at(87, v_wait(3'd0));
    expect_at(88, v_stable(3'd0));
    expect_at(96, v_run(3'd0));
    set_locked(1'b1);
    step_to(84);
    set_locked(1'b0);
    step_to(85);
    set_locked(1'b1);

    // Permanent lock loss from RUN: timeouts then FAIL.
    step_to(100);
    expect_at(103, v_hold(3'd0));
    expect_at(107, v_wait(3'd0));
`ifdef CLK_RST_SEQ_RETRY_EN
    expect_at(127, v_hold(3'd1));
    expect_at(131, v_wait(3'd1));
    expect_at(151, v_hold(3'd2));
    expect_at(155, v_wait(3'd2));
    expect_at(175, v_fail(3'd2));
`else
    expect_at(127, v_fail(3'd0));
`endif
    set_locked(1'b0);

    // FAIL is absorbing, even when lock returns.
    step_to(180);
    set_locked(1'b1);

    // One-cycle reset in FAIL restarts the sequence with lock already present.
    step_to(190);
    expect_at(191, v_hold(3'd0));
    expect_at(195, v_wait(3'd0));
    expect_at(196, v_stable(3'd0));
    expect_at(204, v_run(3'd0));
    reset = 1'b1;
    step_to(191);
    reset = 1'b0;

    // Reset with no lock: a first timeout 4+20 edges after release.
    step_to(206);
    expect_at(207, v_hold(3'd0));
    expect_at(211, v_wait(3'd0));
`ifdef CLK_RST_SEQ_RETRY_EN
    expect_at(231, v_hold(3'd1));
    expect_at(235, v_wait(3'd1));
    // Lock reaches locked_s on the same edge as the second timeout (255): lock wins.
    expect_at(255, v_stable(3'd1));
    expect_at(263, v_run(3'd1));
`else
    expect_at(231, v_fail(3'd0));
`endif
    set_locked(1'b0);
    reset = 1'b1;
    step_to(207);
    reset = 1'b0;

`ifdef CLK_RST_SEQ_RETRY_EN
    step_to(252);
    set_locked(1'b1);
    // Lock loss after a retry leaves retry_cnt at 1.
    step_to(266);
    expect_at(269, v_hold(3'd1));
    expect_at(273, v_wait(3'd1));
    set_locked(1'b0);
    step_to(273);
    expect_at(276, v_stable(3'd1));
    expect_at(284, v_run(3'd1));
    set_locked(1'b1);
    step_to(292);
`else
    step_to(240);
`endif

    // Every scheduled change must have been observed.
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d events still pending, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
